// File: rtl/uart_pkg.sv
// Shared UART definitions: line format enums, the idle line level and the parity helper.
// Used by the framed transmitter and intended for the matching receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic IDLE_LEVEL = 1'b1;

    // data_xor is the reduction XOR of the payload; odd parity is its complement
    function automatic logic parity_of(input parity_e mode, input logic data_xor);
        return data_xor ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter: pulses o_tick on the last clk of every CLKS_PER_BIT.
// i_clear realigns the period to the current cycle so a new frame starts a full bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_baud_tick: CLKS_PER_BIT must be at least 2");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (i_clear || (cnt_q == LAST_CNT)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: configurable width, optional parity, 1 or 2 stop bits,
// valid/ready input with a one-word holding buffer for gap-free back-to-back frames.
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int      CLKS_PER_BIT = 16,
    parameter int      DATA_BITS    = 8,
    parameter parity_e PARITY       = PARITY_NONE,
    parameter int      STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic LAST_STOP  = 1'(STOP_BITS - 1);
    localparam logic HAS_PARITY = (PARITY != PARITY_NONE);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_framed: CLKS_PER_BIT must be at least 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
        $error("uart_tx_framed: DATA_BITS must be in 5..9");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_tx_framed: STOP_BITS must be 1 or 2");
    end

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] buf_q, buf_d;
    logic                 buf_full_q, buf_full_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic tick;
    logic load;
    logic accept;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .i_reset(i_reset),
        .i_clear(load),
        .o_tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        load       = 1'b0;
        accept     = i_valid && !buf_full_q;

        case (state_q)
            IDLE: begin
                if (buf_full_q) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = HAS_PARITY ? uart_pkg::PARITY : STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (tick) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        // A waiting word starts immediately so there is no idle gap
                        if (buf_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d    = START;
            shift_d    = buf_q;
            par_d      = parity_of(PARITY, ^buf_q);
            buf_full_d = 1'b0;
        end

        if (accept) begin
            buf_d      = i_data;
            buf_full_d = 1'b1;
        end
    end

    // The line level is a registered image of the current state's bit
    always_comb begin
        tx_d   = IDLE_LEVEL;
        busy_d = (state_q != IDLE);
        case (state_q)
            IDLE:             tx_d = IDLE_LEVEL;
            START:            tx_d = 1'b0;
            DATA:             tx_d = shift_q[0];
            uart_pkg::PARITY: tx_d = par_q;
            STOP:             tx_d = IDLE_LEVEL;
            default:          tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            tx_q       <= IDLE_LEVEL;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign o_ready = !buf_full_q;
    assign o_tx    = tx_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Scoreboard bench for uart_tx_framed across several line formats, with random words,
// random gaps, backpressure and a mid-frame reset.
module tb_uart_tx_framed;
    import uart_pkg::*;

    localparam int NCFG = 6;
    localparam int CFG_CPB [NCFG] = '{4, 4, 4, 4, 3, 2};
    localparam int CFG_DB  [NCFG] = '{8, 8, 8, 7, 5, 9};
    localparam int CFG_PAR [NCFG] = '{0, 1, 2, 0, 2, 1};
    localparam int CFG_SB  [NCFG] = '{1, 1, 1, 2, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit done [NCFG];

    task automatic chk(input int cfg, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cfg%0d %s: got %0d, expected %0d (t=%0t)", cfg, name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int C    = CFG_CPB[gi];
        localparam int DB   = CFG_DB[gi];
        localparam int PAR  = CFG_PAR[gi];
        localparam int SB   = CFG_SB[gi];
        localparam int NBIT = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
        localparam int LC   = NBIT * C;

        logic          rst = 1'b1;
        logic          vld = 1'b0;
        logic [DB-1:0] din = '0;
        logic          rdy;
        logic          tx;
        logic          busy;

        uart_tx_framed #(
            .CLKS_PER_BIT(C),
            .DATA_BITS   (DB),
            .PARITY      (parity_e'(PAR)),
            .STOP_BITS   (SB)
        ) u_dut (
            .clk    (clk),
            .i_reset(rst),
            .i_data (din),
            .i_valid(vld),
            .o_ready(rdy),
            .o_tx   (tx),
            .o_busy (busy)
        );

        // Reference timing: a frame's start bit appears two edges after acceptance,
        // or straight after the previous frame if that is later.
        int     exp_word_q[$];
        longint exp_start_q[$];
        longint edge_cnt   = 0;
        longint last_start = -1000000;
        longint last_load  = -1000000;
        bit     abort      = 1'b0;

        initial begin : obs
            longint s;
            forever begin
                @(posedge clk);
                edge_cnt++;
                if (rst) begin
                    exp_word_q.delete();
                    exp_start_q.delete();
                    last_start = -1000000;
                    last_load  = -1000000;
                    abort      = 1'b1;
                end else if (vld && rdy) begin
                    s = edge_cnt + 2;
                    if (last_start + LC > s) s = last_start + LC;
                    exp_word_q.push_back(int'(din));
                    exp_start_q.push_back(s);
                    last_start = s;
                    last_load  = s - 1;
                end
            end
        end

        initial begin : mon
            bit     in_frame;
            int     pos;
            logic   bits [0:15];
            int     w;
            int     k;
            longint s;
            in_frame = 1'b0;
            pos      = 0;
            forever begin
                @(negedge clk);
                if (abort) begin
                    abort    = 1'b0;
                    in_frame = 1'b0;
                    chk(gi, "reset tx", tx, 1);
                    chk(gi, "reset busy", busy, 0);
                    chk(gi, "reset ready", rdy, 1);
                end else if (in_frame) begin
                    chk(gi, "tx bit", tx, bits[pos / C]);
                    chk(gi, "busy in frame", busy, 1);
                    pos++;
                    if (pos == LC) in_frame = 1'b0;
                end else if (tx === 1'b0) begin
                    chk(gi, "frame has pending word", exp_word_q.size() != 0, 1);
                    if (exp_word_q.size() != 0) begin
                        w = exp_word_q.pop_front();
                        s = exp_start_q.pop_front();
                        chk(gi, "start cycle", edge_cnt, s);
                        bits[0] = 1'b0;
                        for (int i = 0; i < DB; i++) bits[1 + i] = ((w >> i) & 1) != 0;
                        k = 1 + DB;
                        if (PAR != 0) begin
                            bits[k] = (($countones(w) % 2) == 1) ^ (PAR == 2);
                            k++;
                        end
                        for (int i = 0; i < SB; i++) bits[k + i] = 1'b1;
                        chk(gi, "busy at start", busy, 1);
                        pos      = 1;
                        in_frame = 1'b1;
                    end
                end else begin
                    chk(gi, "idle busy", busy, 0);
                end
            end
        end

        task automatic step();
            @(negedge clk);
            chk(gi, "ready", rdy, (last_load <= edge_cnt));
        endtask

        // Holds valid; while stalled i_data wanders so only the accepted value may be sent
        task automatic send(input int w);
            int n;
            n   = 0;
            vld = 1'b1;
            forever begin
                if (rdy) begin
                    din = DB'(w);
                    step();
                    return;
                end
                din = DB'($urandom);
                step();
                n++;
                if (n > 3 * LC) begin
                    chk(gi, "accept within budget", rdy, 1);
                    return;
                end
            end
        endtask

        task automatic idle(input int n);
            vld = 1'b0;
            din = DB'($urandom);
            repeat (n) step();
        endtask

        initial begin : drv
            int n;
            rst = 1'b1;
            repeat (3) step();
            rst = 1'b0;
            idle(3);
            send(32'hF0); idle(LC + 5);
            send(32'h07); idle(LC + 5);
            send(32'hA5); send(32'h3C); idle(2 * LC + 5);
            send(32'h55); idle(LC + 5);
            repeat (20) begin
                send(int'($urandom));
                if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, LC + 2)));
            end
            idle(2 * LC + 4);
            send(32'hF0);
            send(32'h5A);
            vld = 1'b0;
            n   = 0;
            while (tx !== 1'b0 && n < 2 * LC) begin
                step();
                n++;
            end
            repeat (3 * C + 1) step();
            rst = 1'b1;
            step();
            rst = 1'b0;
            idle(100);
            repeat (8) begin
                send(int'($urandom));
                idle(int'($urandom_range(0, 3)));
            end
            idle(2 * LC + 5);
            chk(gi, "queue drained", exp_word_q.size(), 0);
            done[gi] = 1'b1;
        end
    end

    initial begin : main
        int cyc;
        int ndone;
        cyc   = 0;
        ndone = 0;
        while (ndone < NCFG && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            ndone = 0;
            for (int i = 0; i < NCFG; i++) ndone += done[i] ? 1 : 0;
        end
        chk(-1, "configs finished", ndone, NCFG);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
